// File: rtl/axi_lite_master.sv
// AXI4-Lite master: turns one command into one AXI transaction and returns a single response.
// Define AXI_LITE_MASTER_TIMEOUT_EN to add a watchdog that abandons a stalled handshake.
module axi_lite_master #(
  parameter int unsigned P_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned P_M_AXI_ADDR_WIDTH = 16,
  parameter int unsigned P_TIMEOUT_CYCLES   = 1024
) (
  input  logic                          clock,
  input  logic                          reset,
  // command request
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [P_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [P_M_AXI_DATA_WIDTH-1:0] cmd_wdata,
  // command response
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_write,
  output logic [P_M_AXI_DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic                          rsp_timeout,
  // AXI4-Lite master
  output logic [P_M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [P_M_AXI_DATA_WIDTH-1:0] m_axi_wdata,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  output logic [P_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [P_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_AW_W = 3'd1;
  localparam logic [2:0] WR_B    = 3'd2;
  localparam logic [2:0] RD_AR   = 3'd3;
  localparam logic [2:0] RD_R    = 3'd4;
  localparam logic [2:0] RSP     = 3'd5;

  logic [2:0]                    state_q, state_d;
  logic                          write_q, write_d;
  logic [P_M_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [P_M_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [P_M_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                    resp_q, resp_d;
  logic                          aw_done_q, aw_done_d;
  logic                          w_done_q, w_done_d;
  logic                          aw_hs, w_hs;

  // All outputs come straight from registers, so no valid can follow its ready.
  assign cmd_ready     = (state_q == IDLE);
  assign m_axi_awvalid = (state_q == WR_AW_W) && !aw_done_q;
  assign m_axi_wvalid  = (state_q == WR_AW_W) && !w_done_q;
  assign m_axi_bready  = (state_q == WR_B);
  assign m_axi_arvalid = (state_q == RD_AR);
  assign m_axi_rready  = (state_q == RD_R);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_wdata   = wdata_q;
  assign rsp_valid     = (state_q == RSP);
  assign rsp_write     = write_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;

  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs  = m_axi_wvalid && m_axi_wready;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
  localparam int unsigned CntW = (P_TIMEOUT_CYCLES > 1) ? $clog2(P_TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] tcnt_q, tcnt_d;
  logic            timeout_q, timeout_d;
  logic            waiting, any_hs, timeout_hit;

  assign waiting     = (state_q != IDLE) && (state_q != RSP);
  assign any_hs      = aw_hs || w_hs || (m_axi_bready && m_axi_bvalid) ||
                       (m_axi_arvalid && m_axi_arready) || (m_axi_rready && m_axi_rvalid);
  // Fires on the last of P_TIMEOUT_CYCLES consecutive cycles without progress.
  assign timeout_hit = waiting && !any_hs && (tcnt_q == CntW'(P_TIMEOUT_CYCLES - 1));
  assign tcnt_d      = (!waiting || any_hs || timeout_hit) ? '0 : tcnt_q + 1'b1;
  assign rsp_timeout = timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    timeout_d = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          write_d   = cmd_write;
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          rdata_d   = '0;
          resp_d    = 2'b00;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          state_d   = cmd_write ? WR_AW_W : RD_AR;
        end
      end
      WR_AW_W: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WR_B;
      end
      WR_B: begin
        if (m_axi_bvalid) begin
          resp_d  = m_axi_bresp;
          state_d = RSP;
        end
      end
      RD_AR: begin
        if (m_axi_arready) state_d = RD_R;
      end
      RD_R: begin
        if (m_axi_rvalid) begin
          rdata_d = m_axi_rdata;
          resp_d  = m_axi_rresp;
          state_d = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    if (timeout_hit) begin
      rdata_d   = '0;
      resp_d    = 2'b10;
      timeout_d = 1'b1;
      state_d   = RSP;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= 2'b00;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
      tcnt_q    <= tcnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

endmodule
